// File: rtl/bk_adder_pkg.sv
// ---------------------------------------------------------------------------
// bk_adder_pkg
// Shared definitions for the nibble-serial Brent-Kung add sequencer:
//   - state_t : sequencer state encoding (IDLE / BUSY / DONE)
//   - NIB_W   : width of the shared adder slice
//   - nibbles : number of slice steps needed for a given operand width
// ---------------------------------------------------------------------------
package bk_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nibbles(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/bk_adder4.sv
// ---------------------------------------------------------------------------
// bk_adder4
// Combinational 4-bit Brent-Kung adder slice.
// Ports:
//   a[3:0], b[3:0] : operand nibbles
//   c_in           : carry into bit 0
//   s[3:0]         : sum nibble
//   c_out          : carry out of bit 3
// ---------------------------------------------------------------------------
module bk_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_g10, w_p10;
    logic       w_g32, w_p32;
    logic       w_g20, w_p20;
    logic       w_g30, w_p30;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Up-sweep: pairwise group generate/propagate, then the full span.
    assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
    assign w_p10 = w_p[1] & w_p[0];
    assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
    assign w_p32 = w_p[3] & w_p[2];
    assign w_g30 = w_g32 | (w_p32 & w_g10);
    assign w_p30 = w_p32 & w_p10;

    // Down-sweep: fill in the odd prefix [2:0].
    assign w_g20 = w_g[2] | (w_p[2] & w_g10);
    assign w_p20 = w_p[2] & w_p10;

    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g10  | (w_p10  & c_in);
    assign w_c[3] = w_g20  | (w_p20  & c_in);
    assign w_c[4] = w_g30  | (w_p30  & c_in);

    assign s     = w_p ^ w_c[3:0];
    assign c_out = w_c[4];

endmodule

// File: rtl/bk_add_sequencer.sv
// ---------------------------------------------------------------------------
// bk_add_sequencer
// Adds op_a + op_b + c_in one nibble per clock through a single shared
// Brent-Kung slice, least-significant nibble first. Result is held with a
// valid/ready handshake until consumed.
//
// Optional feature (macro BK_ADD_SEQ_SUB_EN): adds input 'sub'; when set at
// acceptance the sequencer computes op_a - op_b (op_a + ~op_b + 1), c_in is
// ignored.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : request valid          in_ready  : idle, can accept
//   op_a/op_b : WIDTH-bit operands     c_in      : carry into nibble 0
//   sub       : subtract select (BK_ADD_SEQ_SUB_EN builds only)
//   out_valid : result valid           out_ready : consumer accepts
//   sum       : WIDTH-bit result       c_out     : carry out of top nibble
//
// WIDTH must be a multiple of 4 and at least 8.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | stepping the slice over nibble r_idx
// DONE  | result held, out_valid=1 until out_ready
// ---------------------------------------------------------------------------
module bk_add_sequencer
    import bk_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
`ifdef BK_ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NIBS  = nibbles(WIDTH);
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_valid;
    logic               r_ready;

    logic               w_sub;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_init;
    logic [NIB_W-1:0]   w_a_nib;
    logic [NIB_W-1:0]   w_b_nib;
    logic [NIB_W-1:0]   w_s_nib;
    logic               w_c_nib;

`ifdef BK_ADD_SEQ_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is folded in at acceptance: B is stored already inverted
    // and the initial carry forced to 1, so the datapath is add-only.
    assign w_b_load = w_sub ? ~op_b : op_b;
    assign w_c_init = w_sub ? 1'b1  : c_in;

    assign w_a_nib = r_a[r_idx*NIB_W +: NIB_W];
    assign w_b_nib = r_b[r_idx*NIB_W +: NIB_W];

    bk_adder4 u_slice (
        .a     (w_a_nib),
        .b     (w_b_nib),
        .c_in  (r_carry),
        .s     (w_s_nib),
        .c_out (w_c_nib)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= w_b_load;
                        r_carry <= w_c_init;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_sum[r_idx*NIB_W +: NIB_W] <= w_s_nib;
                    r_carry <= w_c_nib;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_c_nib;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises on this edge, so a new request can only
                    // be taken on the following edge.
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign c_out     = r_cout;

endmodule

// File: tb/tb_bk_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bk_add_sequencer
// Self-checking bench for bk_add_sequencer (WIDTH=16). Expected results come
// from plain integer arithmetic on the operands. Define BK_ADD_SEQ_SUB_EN to
// also exercise subtraction.
// ---------------------------------------------------------------------------
module tb_bk_add_sequencer;

    localparam int W    = 16;
    localparam int NIBS = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         c_in;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;

    int errors = 0;
    int checks = 0;

    bk_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .c_in      (c_in),
`ifdef BK_ADD_SEQ_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: request, latency count, result check, optional
    // backpressure of 'hold' cycles, then consume.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input int hold);
        logic [W:0]   exp;
        logic [W-1:0] held_sum;
        logic         held_c;
        int           n;
        if (sb) exp = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else    exp = {1'b0, a} + {1'b0, b} + (W+1)'(ci);

        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_before_req", 32'(in_ready), 32'd1);

        op_a = a; op_b = b; c_in = ci; sub_i = sb;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        // Inputs scrambled after acceptance must not affect the result.
        in_valid = $urandom_range(0, 1);
        op_a = W'($urandom); op_b = W'($urandom);
        c_in = 1'($urandom); sub_i = 1'($urandom);
        chk("in_ready_busy", 32'(in_ready), 32'd0);

        n = 0;
        while (!out_valid && n < 4 * NIBS + 10) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("latency", 32'(n), 32'(NIBS));
        chk("sum", 32'(sum), 32'(exp[W-1:0]));
        chk("c_out", 32'(c_out), 32'(exp[W]));

        held_sum = exp[W-1:0];
        held_c   = exp[W];
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(held_sum));
            chk("hold_cout", 32'(c_out), 32'(held_c));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_valid", 32'(out_valid), 32'd0);
        chk("consume_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; c_in = 1'b0; sub_i = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(16'h0003, 16'h0002, 1'b0, 1'b0, 0);
        run_op(16'h000B, 16'h0006, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, 10);

        // Reset on the second BUSY edge abandons the operation.
        op_a = 16'h7777; op_b = 16'h8888; c_in = 1'b1; sub_i = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(c_out), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * NIBS; i++) begin
            tick();
            chk("midrst_no_result", 32'(out_valid), 32'd0);
        end
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);

`ifdef BK_ADD_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            logic sb;
`ifdef BK_ADD_SEQ_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), sb,
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
